// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: fetch FSM encoding, the canonical NOP and the reset vector.
package riscv_pkg;

    typedef enum logic [1:0] {
        ISSUE   = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2,
        HOLD    = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id.sv
// IF/ID pipeline register: flush beats stall, stall beats a new load, otherwise a bubble.
module if_id
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        flush_i,
    input  logic        stall_i,
    input  logic        load_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] pcplus4_i,
    input  logic [31:0] instr_i,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic [31:0] InstrD,
    output logic        ValidD
);

    logic [31:0] pc_q;
    logic [31:0] pcplus4_q;
    logic [31:0] instr_q;
    logic        valid_q;

    // A bubble keeps the old PC fields and only replaces the instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q      <= 32'h0;
            pcplus4_q <= 32'h0;
            instr_q   <= NOP_INSTR;
            valid_q   <= 1'b0;
        end else if (flush_i) begin
            instr_q   <= NOP_INSTR;
            valid_q   <= 1'b0;
        end else if (!stall_i) begin
            if (load_i) begin
                pc_q      <= pc_i;
                pcplus4_q <= pcplus4_i;
                instr_q   <= instr_i;
                valid_q   <= 1'b1;
            end else begin
                instr_q   <= NOP_INSTR;
                valid_q   <= 1'b0;
            end
        end
    end

    assign PCD      = pc_q;
    assign PCPlus4D = pcplus4_q;
    assign InstrD   = instr_q;
    assign ValidD   = valid_q;

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: one outstanding imem request, redirect handling and a one-deep
// holding buffer for a response that arrives while decode is stalled.
module ifetch
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic [31:0] InstrD,
    output logic        ValidD
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pcf_q, pcf_d;
    logic [31:0]  out_pc_q, out_pc_d;
    logic [31:0]  buf_instr_q, buf_instr_d;

    logic         deliver;
    logic [31:0]  del_instr;
    logic [31:0]  target;

    assign target = word_align(PCTargetE);

    always_comb begin
        state_d     = state_q;
        pcf_d       = pcf_q;
        out_pc_d    = out_pc_q;
        buf_instr_d = buf_instr_q;
        deliver     = 1'b0;
        del_instr   = imem_rdata;
        case (state_q)
            ISSUE: begin
                if (PCSrcE) begin
                    pcf_d = target;
                end else if (imem_gnt) begin
                    out_pc_d = pcf_q;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (PCSrcE) begin
                        pcf_d   = target;
                        state_d = ISSUE;
                    end else if (StallD) begin
                        buf_instr_d = imem_rdata;
                        state_d     = HOLD;
                    end else begin
                        deliver = 1'b1;
                        pcf_d   = pcf_q + 32'd4;
                        state_d = ISSUE;
                    end
                end else if (PCSrcE) begin
                    pcf_d   = target;
                    state_d = DISCARD;
                end
            end
            DISCARD: begin
                if (PCSrcE) begin
                    pcf_d = target;
                end
                if (imem_rvalid) begin
                    state_d = ISSUE;
                end
            end
            HOLD: begin
                // The buffered word's PC is still the outstanding PC, so only the word is kept.
                if (PCSrcE) begin
                    pcf_d   = target;
                    state_d = ISSUE;
                end else if (!StallD) begin
                    deliver   = 1'b1;
                    del_instr = buf_instr_q;
                    pcf_d     = pcf_q + 32'd4;
                    state_d   = ISSUE;
                end
            end
            default: state_d = ISSUE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ISSUE;
            pcf_q       <= RESET_PC;
            out_pc_q    <= RESET_PC;
            buf_instr_q <= NOP_INSTR;
        end else begin
            state_q     <= state_d;
            pcf_q       <= pcf_d;
            out_pc_q    <= out_pc_d;
            buf_instr_q <= buf_instr_d;
        end
    end

    assign imem_req  = reset && (state_q == ISSUE) && !PCSrcE;
    assign imem_addr = pcf_q;

    if_id u_if_id (
        .clk       (clk),
        .reset     (reset),
        .flush_i   (FlushD),
        .stall_i   (StallD),
        .load_i    (deliver),
        .pc_i      (out_pc_q),
        .pcplus4_i (out_pc_q + 32'd4),
        .instr_i   (del_instr),
        .PCD       (PCD),
        .PCPlus4D  (PCPlus4D),
        .InstrD    (InstrD),
        .ValidD    (ValidD)
    );

endmodule

// File: doc/ifetch.md
# ifetch

Instruction-fetch stage of the five-stage RISC-V pipeline. It owns the fetch PC and issues one instruction-memory request at a time over a valid/grant/response handshake. It applies branch/jump redirects from Execute and writes the IF/ID pipeline register that drives the decode stage inputs PCD, InstrD and PCPlus4D. The block tolerates variable memory latency and decode stalls by inserting NOP bubbles and holding one fetched instruction in a single-entry buffer.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
- StallD  in  1  hazard unit: hold IF/ID contents
- FlushD  in  1  hazard unit: replace IF/ID contents with a bubble
- PCSrcE  in  1  Execute: redirect fetch (taken branch/jump)
- PCTargetE  in  32  redirect target
- imem_req  out  1  request valid
- imem_addr  out  32  request address (word aligned)
- imem_gnt  in  1  memory accepts request this cycle
- imem_rvalid  in  1  response data valid; in order, at most one outstanding
- imem_rdata  in  32  instruction word
- PCD, PCPlus4D  out  32  IF/ID PC and PC+4
- InstrD  out  32  IF/ID instruction
- ValidD  out  1  InstrD is a real fetched instruction (0 = bubble)

## Operation
- State machine fetch_state_t: ISSUE, WAIT, DISCARD, HOLD.
- ISSUE:
  - imem_req = !PCSrcE; imem_addr = PCF.
  - If PCSrcE: PCF <= {PCTargetE[31:2],2'b00} and stay in ISSUE.
  - Else if imem_gnt: latch PCF as the outstanding PC and go to WAIT.
- WAIT (imem_req=0):
  - rvalid & !PCSrcE & !StallD: load IF/ID with the outstanding PC, its PC+4 and rdata; ValidD=1; PCF <= PCF+4; go to ISSUE.
  - rvalid & !PCSrcE & StallD: store rdata and the PC in the buffer; go to HOLD.
  - rvalid & PCSrcE: drop the response, PCF <= target, go to ISSUE.
  - !rvalid & PCSrcE: PCF <= target, go to DISCARD.
- DISCARD: imem_req=0. The next rvalid is dropped and the block goes to ISSUE. A further PCSrcE here updates PCF only.
- HOLD: imem_req=0.
  - !StallD: load IF/ID from the buffer, PCF <= PCF+4, go to ISSUE.
  - PCSrcE: drop the buffer, PCF <= target, go to ISSUE (PCSrcE has priority over the buffer release).
- IF/ID update priority: FlushD > StallD > fetch delivery > bubble.
  - FlushD: InstrD=NOP, ValidD=0, PCD and PCPlus4D unchanged.
  - No delivery and !StallD: bubble, encoded the same as FlushD.
- Arithmetic: PC+4 wraps modulo 2^32. Target bits [1:0] are forced to 0.

## Timing
- Reset (asynchronous, while reset=0):
  - state=ISSUE, PCF=RESET_PC, imem_req=0.
  - PCD=0, PCPlus4D=0, InstrD=32'h0000_0013, ValidD=0.
  - The first request is issued in the first clock after reset deasserts.
- imem_req, imem_addr and the state are derived combinationally from registered state plus PCSrcE. The request is held stable until imem_gnt.
- Minimum latency is request cycle + one response cycle; InstrD is updated at the edge after the rvalid cycle. Zero-wait memory therefore sustains one instruction per 2 cycles.
- The buffer (HOLD) is capacity one; no further request is issued until it drains.
- Reset mid-WAIT: the state returns to ISSUE. The memory must abandon the outstanding response under the same reset.
- A PCSrcE coincident with FlushD in the same cycle is expected and legal.

## Structure
- Package riscv_pkg:
  - fetch_state_t enum.
  - NOP_INSTR = 32'h0000_0013.
  - RESET_PC default.
- Sub-module if_id: the IF/ID register with flush and stall enables, holding PCD, PCPlus4D, InstrD and ValidD. It is the counterpart of id_ex.
- ifetch holds the FSM, PCF, the outstanding-PC register and the one-entry buffer.

## Test plan
- Reset release, memory rvalid one cycle after gnt, words 0x00500093, 0x00A00113:
  - imem_addr = 0x0, then 0x4.
  - PCD = 0x0 with InstrD = 0x00500093, then PCD = 0x4 with InstrD = 0x00A00113.
  - ValidD = 1 on each delivery and 0 (NOP) between deliveries.
- Memory holds imem_gnt low for 3 cycles: imem_req and imem_addr stay stable at 0x8, and IF/ID receives bubbles with ValidD = 0.
- PCSrcE with target 0x100 while in WAIT, response arrives 2 cycles later:
  - The stale word is dropped.
  - The next imem_addr = 0x100.
  - PCD = 0x100 is the first valid delivery after the redirect.
- StallD high for 4 cycles when rvalid arrives:
  - IF/ID is unchanged and no new request is issued.
  - On the StallD release edge, InstrD = the buffered word and the next request goes to PC+4.
- FlushD and StallD asserted together: InstrD = 0x00000013 and ValidD = 0 (flush wins).
- PCF = 0xFFFF_FFFC fetched: PCPlus4D = 0x0000_0000 and the next imem_addr = 0x0; PCTargetE = 0x103 gives imem_addr 0x100.
